// File: rtl/motor_drive_pkg.sv
// Shared types and duty constants for the motor drive controller.
package motor_drive_pkg;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    DWELL = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam int SPIN_DUTY_0 = 128;
  localparam int SPIN_DUTY_1 = 176;
  localparam int SPIN_DUTY_2 = 224;
  localparam int SPIN_DUTY_3 = 255;
  localparam int AGIT_DUTY   = 96;

  function automatic int spin_duty(input logic [1:0] sel);
    case (sel)
      2'b00:   return SPIN_DUTY_0;
      2'b01:   return SPIN_DUTY_1;
      2'b10:   return SPIN_DUTY_2;
      default: return SPIN_DUTY_3;
    endcase
  endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running PWM counter with registered compare against the duty value.
module motor_pwm_gen #(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_pwm
);

  logic [DUTY_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      o_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      o_pwm <= (r_cnt < i_duty);
    end
  end

endmodule

// File: rtl/motor_drive_ctrl.sv
// Soft-start PWM motor drive: duty ramping, agitation reversal with dwell, brake and interlock fault.
// Optional reversal counter output rev_count when MOTOR_REV_COUNT_EN is defined.
//
// state | meaning
// STOP  | motor idle, brake on, duty 0
// RAMP  | duty stepping toward target
// RUN   | duty at target, agitation on-timer running
// DWELL | zero duty pause between agitation reversals, brake off
// FAULT | door opened while running; held until motor_on drops
module motor_drive_ctrl
  import motor_drive_pkg::*;
#(
  parameter int DUTY_W         = 8,
  parameter int RAMP_DIV       = 4,
  parameter int RAMP_STEP      = 16,
  parameter int AGIT_ON_CYC    = 64,
  parameter int AGIT_DWELL_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              motor_on,
  input  logic              door_locked,
  input  logic              spin_mode,
  input  logic [1:0]        speed_sel,
  output logic              pwm_out,
  output logic              dir,
  output logic              brake,
  output logic              at_speed,
  output logic              fault,
  output logic [DUTY_W-1:0] duty
`ifdef MOTOR_REV_COUNT_EN
  ,output logic [15:0]      rev_count
`endif
);

  localparam int PRE_W = $clog2(RAMP_DIV + 1);
  localparam int RUN_W = $clog2(AGIT_ON_CYC + 1);
  localparam int DWL_W = $clog2(AGIT_DWELL_CYC + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);

  state_t            r_state, w_nxt_state;
  logic [DUTY_W-1:0] r_duty, w_nxt_duty, w_tgt, w_ramp;
  logic              r_dir, w_nxt_dir;
  logic              r_agit_on, w_nxt_agit;
  logic [PRE_W-1:0]  r_pre, w_nxt_pre;
  logic [RUN_W-1:0]  r_run, w_nxt_run;
  logic [DWL_W-1:0]  r_dwell, w_nxt_dwell;
`ifdef MOTOR_REV_COUNT_EN
  logic [15:0]       r_rev, w_nxt_rev;
`endif

  always_comb begin
    w_tgt = '0;
    if (!motor_on)
      w_tgt = '0;
    else if (spin_mode)
      w_tgt = DUTY_W'(spin_duty(speed_sel));
    else if (r_agit_on)
      w_tgt = DUTY_W'(AGIT_DUTY);
  end

  // One ramp step toward target, clamped so it never overshoots or wraps.
  always_comb begin
    w_ramp = w_tgt;
    if (r_duty < w_tgt)
      w_ramp = ((w_tgt - r_duty) <= STEP) ? w_tgt : r_duty + STEP;
    else if (r_duty > w_tgt)
      w_ramp = ((r_duty - w_tgt) <= STEP) ? w_tgt : r_duty - STEP;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_duty  = r_duty;
    w_nxt_dir   = r_dir;
    w_nxt_agit  = r_agit_on;
    w_nxt_pre   = r_pre;
    w_nxt_run   = r_run;
    w_nxt_dwell = r_dwell;
`ifdef MOTOR_REV_COUNT_EN
    w_nxt_rev   = r_rev;
`endif
    if (motor_on && !door_locked && r_state != FAULT) begin
      w_nxt_state = FAULT;
      w_nxt_duty  = '0;
    end else begin
      case (r_state)
        STOP: begin
          w_nxt_duty = '0;
          if (motor_on && door_locked) begin
            w_nxt_state = RAMP;
            w_nxt_dir   = 1'b0;
            w_nxt_agit  = 1'b1;
            w_nxt_pre   = '0;
          end
        end
        RAMP: begin
          if (r_duty == w_tgt) begin
            w_nxt_pre = '0;
            if (w_tgt != '0) begin
              w_nxt_state = RUN;
              w_nxt_run   = RUN_W'(AGIT_ON_CYC);
            end else if (motor_on && !spin_mode) begin
              w_nxt_state = DWELL;
              w_nxt_dwell = DWL_W'(AGIT_DWELL_CYC);
            end else begin
              w_nxt_state = STOP;
            end
          end else if (r_pre == PRE_LAST) begin
            w_nxt_pre  = '0;
            w_nxt_duty = w_ramp;
          end else begin
            w_nxt_pre = r_pre + 1'b1;
          end
        end
        RUN: begin
          if (r_duty != w_tgt) begin
            w_nxt_state = RAMP;
            w_nxt_pre   = '0;
          end else if (!spin_mode) begin
            w_nxt_run = r_run - 1'b1;
            if (r_run <= RUN_W'(1)) begin
              w_nxt_agit  = 1'b0;
              w_nxt_state = RAMP;
              w_nxt_pre   = '0;
            end
          end
        end
        DWELL: begin
          w_nxt_duty = '0;
          if (!motor_on) begin
            w_nxt_state = STOP;
          end else if (spin_mode) begin
            w_nxt_dir   = 1'b0;
            w_nxt_agit  = 1'b1;
            w_nxt_state = RAMP;
            w_nxt_pre   = '0;
          end else if (r_dwell <= DWL_W'(1)) begin
            w_nxt_dir   = ~r_dir;
            w_nxt_agit  = 1'b1;
            w_nxt_state = RAMP;
            w_nxt_pre   = '0;
`ifdef MOTOR_REV_COUNT_EN
            if (r_rev != 16'hFFFF)
              w_nxt_rev = r_rev + 16'd1;
`endif
          end else begin
            w_nxt_dwell = r_dwell - 1'b1;
          end
        end
        FAULT: begin
          w_nxt_duty = '0;
          if (!motor_on)
            w_nxt_state = STOP;
        end
        default: begin
          w_nxt_state = STOP;
          w_nxt_duty  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= STOP;
      r_duty    <= '0;
      r_dir     <= 1'b0;
      r_agit_on <= 1'b1;
      r_pre     <= '0;
      r_run     <= '0;
      r_dwell   <= '0;
`ifdef MOTOR_REV_COUNT_EN
      r_rev     <= '0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_duty    <= w_nxt_duty;
      r_dir     <= w_nxt_dir;
      r_agit_on <= w_nxt_agit;
      r_pre     <= w_nxt_pre;
      r_run     <= w_nxt_run;
      r_dwell   <= w_nxt_dwell;
`ifdef MOTOR_REV_COUNT_EN
      r_rev     <= w_nxt_rev;
`endif
    end
  end

  assign duty     = r_duty;
  assign dir      = r_dir;
  assign at_speed = (r_state == RUN);
  assign brake    = (r_state == STOP) || (r_state == FAULT);
  assign fault    = (r_state == FAULT);
`ifdef MOTOR_REV_COUNT_EN
  assign rev_count = r_rev;
`endif

  motor_pwm_gen #(.DUTY_W(DUTY_W)) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .i_duty (r_duty),
    .o_pwm  (pwm_out)
  );

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Scoreboard bench for motor_drive_ctrl: stimulus queues timed expectations, a monitor checks them.
module tb_motor_drive_ctrl;

  localparam int S_DUTY = 0, S_DIR = 1, S_BRAKE = 2, S_ATSPD = 3, S_FAULT = 4, S_PWM = 5, S_REV = 6;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, motor_on, door_locked, spin_mode;
  logic [1:0] speed_sel;
  logic       pwm_out, dir, brake, at_speed, fault;
  logic [7:0] duty;
`ifdef MOTOR_REV_COUNT_EN
  logic [15:0] rev_count;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  motor_drive_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .motor_on    (motor_on),
    .door_locked (door_locked),
    .spin_mode   (spin_mode),
    .speed_sel   (speed_sel),
    .pwm_out     (pwm_out),
    .dir         (dir),
    .brake       (brake),
    .at_speed    (at_speed),
    .fault       (fault),
    .duty        (duty)
`ifdef MOTOR_REV_COUNT_EN
    ,.rev_count  (rev_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int s);
    case (s)
      S_DUTY:  return int'(duty);
      S_DIR:   return int'(dir);
      S_BRAKE: return int'(brake);
      S_ATSPD: return int'(at_speed);
      S_FAULT: return int'(fault);
      S_PWM:   return int'(pwm_out);
`ifdef MOTOR_REV_COUNT_EN
      S_REV:   return int'(rev_count);
`endif
      default: return -1;
    endcase
  endfunction

  // Queue kept sorted by check cycle.
  task automatic push_exp(input int d, input int s, input int v, input string nm);
    exp_t e;
    int   i;
    e.cyc = cyc + d; e.sig = s; e.val = v; e.name = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops every expectation due this cycle; also checks dir never moves while duty is nonzero.
  logic [7:0] prev_duty = '0;
  logic       prev_dir  = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        int   a;
        e = q.pop_front();
        a = actual(e.sig);
        n_checks++;
        if (e.cyc != cyc || a != e.val) begin
          n_errors++;
          $display("FAIL %s at cycle %0d (due %0d): got %0d expected %0d", e.name, cyc, e.cyc, a, e.val);
        end
      end
      if (reset === 1'b1 && prev_duty != 0 && duty != 0) begin
        n_checks++;
        if (dir !== prev_dir) begin
          n_errors++;
          $display("FAIL dir_stable at cycle %0d: got %0b expected %0b", cyc, dir, prev_dir);
        end
      end
      prev_duty = duty;
      prev_dir  = dir;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; motor_on = 1'b0; door_locked = 1'b0; spin_mode = 1'b0; speed_sel = 2'b00;
    tick(2);
    push_exp(1, S_DUTY, 0, "rst_duty");   push_exp(1, S_BRAKE, 1, "rst_brake");
    push_exp(1, S_DIR, 0, "rst_dir");     push_exp(1, S_ATSPD, 0, "rst_at_speed");
    push_exp(1, S_FAULT, 0, "rst_fault"); push_exp(1, S_PWM, 0, "rst_pwm");
    tick(2);

    // Spin at 255 from reset release
    reset = 1'b1; motor_on = 1'b1; door_locked = 1'b1; spin_mode = 1'b1; speed_sel = 2'b11;
    push_exp(2, S_BRAKE, 0, "spin_ramp_brake");
    push_exp(4, S_DUTY, 0, "spin_hold_before_step");
    push_exp(5, S_DUTY, 16, "spin_step1");
    push_exp(9, S_DUTY, 32, "spin_step2");
    push_exp(61, S_DUTY, 240, "spin_step15");
    push_exp(64, S_DUTY, 240, "spin_hold240");
    push_exp(65, S_DUTY, 255, "spin_clamp255");
    push_exp(65, S_ATSPD, 0, "spin_atspd_early");
    push_exp(66, S_ATSPD, 1, "spin_atspd");
    push_exp(66, S_DIR, 0, "spin_dir");
    push_exp(255, S_PWM, 1, "pwm255_hi_a");
    push_exp(256, S_PWM, 0, "pwm255_lo");
    push_exp(257, S_PWM, 1, "pwm255_hi_b");
    tick(258);

    // Door opens at full speed
    door_locked = 1'b0;
    push_exp(1, S_FAULT, 1, "flt_assert"); push_exp(1, S_DUTY, 0, "flt_duty");
    push_exp(1, S_BRAKE, 1, "flt_brake");  push_exp(1, S_ATSPD, 0, "flt_atspd");
    push_exp(2, S_PWM, 0, "flt_pwm");
    tick(3);
    door_locked = 1'b1;
    push_exp(2, S_FAULT, 1, "flt_hold"); push_exp(2, S_DUTY, 0, "flt_hold_duty");
    tick(3);
    motor_on = 1'b0;
    push_exp(1, S_FAULT, 0, "flt_clear"); push_exp(1, S_BRAKE, 1, "flt_stop_brake");
    tick(3);

    // Spin 224, then speed change down to 128
    motor_on = 1'b1; speed_sel = 2'b10;
    push_exp(56, S_DUTY, 208, "s224_pre");
    push_exp(57, S_DUTY, 224, "s224_reach");
    push_exp(58, S_ATSPD, 1, "s224_atspd");
    tick(60);
    speed_sel = 2'b00;
    push_exp(1, S_ATSPD, 0, "sc_drop");
    push_exp(4, S_DUTY, 224, "sc_hold");
    push_exp(5, S_DUTY, 208, "sc_step1");
    push_exp(25, S_DUTY, 128, "sc_step6");
    push_exp(25, S_ATSPD, 0, "sc_atspd_early");
    push_exp(26, S_ATSPD, 1, "sc_rerun");
    tick(30);

    // Stop from 128
    motor_on = 1'b0;
    push_exp(33, S_DUTY, 0, "stop128_zero");
    push_exp(33, S_BRAKE, 0, "stop128_ramp_brake");
    push_exp(34, S_BRAKE, 1, "stop128_brake");
    tick(36);

    // motor_on drops mid-ramp at duty 48
    motor_on = 1'b1;
    push_exp(13, S_DUTY, 48, "mid_48");
    tick(13);
    motor_on = 1'b0;
    push_exp(4, S_DUTY, 32, "mid_dn1");
    push_exp(8, S_DUTY, 16, "mid_dn2");
    push_exp(12, S_DUTY, 0, "mid_dn3");
    push_exp(12, S_BRAKE, 0, "mid_ramp_brake");
    push_exp(13, S_BRAKE, 1, "mid_stop_brake");
    tick(15);

    // Reset pulse between clock edges mid-ramp
    motor_on = 1'b1;
    push_exp(9, S_DUTY, 32, "arst_pre");
    tick(10);
    push_exp(1, S_DUTY, 0, "arst_duty");
    push_exp(1, S_BRAKE, 1, "arst_brake");
    push_exp(1, S_PWM, 0, "arst_pwm");
    #1 reset = 1'b0; motor_on = 1'b0;
    #2 reset = 1'b1;
    tick(3);

    // Agitation with three reversals
    motor_on = 1'b1; spin_mode = 1'b0;
    push_exp(24, S_DUTY, 80, "ag_step5");
    push_exp(25, S_DUTY, 96, "ag_reach96");
    push_exp(26, S_ATSPD, 1, "ag_run");
    push_exp(89, S_ATSPD, 1, "ag_run_last");
    push_exp(90, S_ATSPD, 0, "ag_run_end");
    push_exp(90, S_DUTY, 96, "ag_dn_hold");
    push_exp(113, S_DUTY, 16, "ag_dn5");
    push_exp(114, S_DUTY, 0, "ag_dn6");
    push_exp(115, S_BRAKE, 0, "ag_dwell_brake");
    push_exp(125, S_DUTY, 0, "ag_dwell_duty");
    push_exp(130, S_DIR, 0, "ag_dir_before");
    push_exp(130, S_BRAKE, 0, "ag_dwell_brake_end");
    push_exp(131, S_DIR, 1, "ag_dir_rev1");
    push_exp(135, S_DUTY, 16, "ag_reramp");
    push_exp(156, S_ATSPD, 1, "ag_run2");
    push_exp(260, S_DIR, 1, "ag_dir_before2");
    push_exp(261, S_DIR, 0, "ag_dir_rev2");
    push_exp(391, S_DIR, 1, "ag_dir_rev3");
`ifdef MOTOR_REV_COUNT_EN
    push_exp(130, S_REV, 0, "rev_0");
    push_exp(131, S_REV, 1, "rev_1");
    push_exp(390, S_REV, 2, "rev_2");
    push_exp(391, S_REV, 3, "rev_3");
`endif
    tick(395);
    motor_on = 1'b0;

    begin
      int k;
      k = 0;
      while (q.size() > 0 && k < 1000) begin
        tick(1);
        k++;
      end
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no sample expected %0d", e.name, e.val);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/motor_drive_ctrl.md
Name: motor_drive_ctrl

Overview:
- Downstream of the washing-machine controller FSM; consumes its motor_on and door_locked outputs plus the cycle/spin selection.
- Converts them into a soft-started PWM motor drive: duty ramping, agitation direction reversal with dwell, a brake output and a door-interlock fault.
- Output feeds the motor power stage.

Parameters:
- DUTY_W, 8, width of the duty register and PWM counter.
- RAMP_DIV, 4, clocks per ramp step.
- RAMP_STEP, 16, duty change per ramp step.
- AGIT_ON_CYC, 64, clocks the motor holds agitation speed before reversing.
- AGIT_DWELL_CYC, 16, clocks at zero duty between agitation reversals.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- motor_on  input  1  run request from the controller FSM.
- door_locked  input  1  interlock; must be high while the motor runs.
- spin_mode  input  1  0 = agitate (wash/rinse), 1 = spin.
- speed_sel  input  2  spin speed selector.
- pwm_out  output  1  PWM gate drive.
- dir  output  1  0 = CW, 1 = CCW.
- brake  output  1  dynamic brake enable.
- at_speed  output  1  duty equals target.
- fault  output  1  interlock violation.
- duty  output  DUTY_W  current duty (observability).

Behaviour:
- Reset (reset=0, asynchronous): state=STOP, duty=0, dir=0, brake=1, pwm_out=0, at_speed=0, fault=0, agit_on=1, all counters=0.
- Target tgt (combinational):
  - motor_on=0 -> 0.
  - spin_mode=1 -> table by speed_sel: 00:128, 01:176, 10:224, 11:255.
  - spin_mode=0 -> 96 when agit_on, else 0.
- PWM: free-running DUTY_W counter. pwm_out = (cnt < duty), registered. duty=255 gives 255/256 high; duty=0 keeps pwm_out low.
- States:
  - STOP: brake=1, duty=0.
    - motor_on & door_locked -> RAMP; dir=0, agit_on=1, ramp prescaler cleared.
  - RAMP: every RAMP_DIV clocks, duty steps by RAMP_STEP toward tgt, clamped to tgt with no overshoot and no wrap; the first step lands RAMP_DIV clocks after entry. When duty==tgt:
    - tgt!=0 -> RUN; run counter loaded with AGIT_ON_CYC.
    - tgt==0 & motor_on & !spin_mode -> DWELL; dwell counter loaded.
    - otherwise -> STOP.
  - RUN: at_speed=1.
    - Agitate mode: run counter decrements; at 0, agit_on=0 -> RAMP (ramp down to 0).
    - duty!=tgt (speed_sel, spin_mode or motor_on changed) -> RAMP next cycle.
  - DWELL: duty=0, brake=0.
    - At end of count: dir toggles, agit_on=1 -> RAMP.
    - motor_on=0 -> STOP.
    - spin_mode=1 -> dir=0, agit_on=1 -> RAMP.
  - FAULT: duty=0, brake=1, fault=1.
    - Exit to STOP only when motor_on=0.
- Fault priority: motor_on=1 & door_locked=0 in any state except FAULT -> FAULT on the next edge, overriding every other transition. Duty is forced to 0 in that same edge, with no ramp.
- Direction changes only while duty==0 (STOP, DWELL); never mid-ramp.
- at_speed is high only in RUN.
- Reset mid-ramp or in FAULT returns to reset values immediately.

Optional Feature:
- MOTOR_REV_COUNT_EN defined:
  - Adds output rev_count[15:0], incremented on every dir toggle in DWELL.
  - Saturates at 16'hFFFF; cleared only by reset.
- Not defined: the port and counter are absent; all other behaviour is unchanged.

Decomposition:
- Package motor_drive_pkg:
  - state enum (STOP, RAMP, RUN, DWELL, FAULT);
  - spin duty table constants;
  - AGIT_DUTY=96.
- One sub-module, motor_pwm_gen: counter plus compare, producing pwm_out from duty.
- Ramp, agitation and FSM logic stay in motor_drive_ctrl.

Test Plan:
- Reset release, motor_on=1, door_locked=1, spin_mode=1, speed_sel=11 -> duty rises 16 every 4 clocks, clamps at 255 after 64 clocks in RAMP, at_speed=1 next cycle, dir=0.
- Agitate (spin_mode=0) -> duty 96 after 24 clocks; RUN holds 64 clocks; ramp to 0 in 24 clocks; DWELL 16 clocks with brake=0; dir toggles to 1; ramp up again. Check dir constant whenever duty!=0.
- In RUN at 255, drop door_locked -> next edge fault=1, duty=0, brake=1. Raising door_locked keeps FAULT; motor_on=0 -> STOP, fault=0.
- In RUN at 224, switch speed_sel 10->00 -> at_speed drops, duty steps down 224->128 in 6 steps (24 clocks), RUN re-entered.
- motor_on=0 mid-ramp at duty 48 -> ramps to 0 in 3 steps, STOP, brake=1. Separately, reset pulse mid-ramp -> all outputs at reset values asynchronously.
- With MOTOR_REV_COUNT_EN: 3 full agitation reversals -> rev_count=3. Without the macro: bench compiles with no rev_count port.
